// File: rtl/dpram_pkg.sv
// dpram_pkg: shared word/address widths and types for the dual-port RAM family.
package dpram_pkg;
    localparam int DPRAM_DATA_WIDTH = 16;
    localparam int DPRAM_ADDR_WIDTH = 11;
    typedef logic [DPRAM_ADDR_WIDTH-1:0] dpram_addr_t;
    typedef logic [DPRAM_DATA_WIDTH-1:0] dpram_data_t;
endpackage

// File: rtl/dpram_2048x16_cb.sv
// dpram_2048x16_cb: single-clock true dual-port 2048x16 RAM with active-low macro-style controls.
// DPRAM_BYPASS_EN selects write-first cross-port collisions; default is read-first.
module dpram_2048x16_cb
    import dpram_pkg::*;
#(
    parameter int DATA_WIDTH = DPRAM_DATA_WIDTH,
    parameter int ADDR_WIDTH = DPRAM_ADDR_WIDTH,
    parameter int DEPTH = 2**ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_N,
    input  logic [ADDR_WIDTH-1:0] A1,
    input  logic [ADDR_WIDTH-1:0] A2,
    input  logic                  CSB1,
    input  logic                  CSB2,
    input  logic                  WEB1,
    input  logic                  WEB2,
    input  logic                  OEB1,
    input  logic                  OEB2,
    input  logic [DATA_WIDTH-1:0] I1,
    input  logic [DATA_WIDTH-1:0] I2,
    output logic [DATA_WIDTH-1:0] O1,
    output logic [DATA_WIDTH-1:0] O2
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] out_reg_1, out_reg_2, rd_data_1, rd_data_2;
    logic we_1, we_2, rd_1, rd_2, same_addr;

    assign we_1 = !CSB1 && !WEB1;
    assign we_2 = !CSB2 && !WEB2;
    assign rd_1 = !CSB1 && WEB1;
    assign rd_2 = !CSB2 && WEB2;
    assign same_addr = A1 == A2;

`ifdef DPRAM_BYPASS_EN
    assign rd_data_1 = we_2 && same_addr ? I2 : mem[A1];
    assign rd_data_2 = we_1 && same_addr ? I1 : mem[A2];
`else
    assign rd_data_1 = mem[A1];
    assign rd_data_2 = mem[A2];
`endif

    // Port 1 wins a same-address dual write, so port 2 is dropped there.
    always_ff @(posedge clk) begin
        if (!reset_N) begin
            if (we_2 && !(we_1 && same_addr)) mem[A2] <= I2;
            if (we_1) mem[A1] <= I1;
        end
    end

    always_ff @(posedge clk or posedge reset_N) begin
        if (reset_N) out_reg_1 <= '0;
        else if (rd_1) out_reg_1 <= rd_data_1;
    end

    always_ff @(posedge clk or posedge reset_N) begin
        if (reset_N) out_reg_2 <= '0;
        else if (rd_2) out_reg_2 <= rd_data_2;
    end

    assign O1 = OEB1 ? {DATA_WIDTH{1'bz}} : out_reg_1;
    assign O2 = OEB2 ? {DATA_WIDTH{1'bz}} : out_reg_2;
endmodule

// File: tb/tb_dpram_2048x16_cb.sv
// tb_dpram_2048x16_cb: directed self-checking bench for dpram_2048x16_cb.
module tb_dpram_2048x16_cb;
    logic clk = 0, reset_N = 1;
    logic [10:0] A1 = 0, A2 = 0;
    logic CSB1 = 1, CSB2 = 1, WEB1 = 1, WEB2 = 1, OEB1 = 0, OEB2 = 0;
    logic [15:0] I1 = 0, I2 = 0;
    wire [15:0] O1, O2;
    int n_tests = 0, n_fail = 0;

    dpram_2048x16_cb dut (
        .clk(clk), .reset_N(reset_N), .A1(A1), .A2(A2),
        .CSB1(CSB1), .CSB2(CSB2), .WEB1(WEB1), .WEB2(WEB2),
        .OEB1(OEB1), .OEB2(OEB2), .I1(I1), .I2(I2), .O1(O1), .O2(O2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        CSB1 = 1; CSB2 = 1; WEB1 = 1; WEB2 = 1;
    endtask

    initial begin
        tick; tick;
        chk("reset_o1", O1, 16'h0000);
        chk("reset_o2", O2, 16'h0000);
        reset_N = 0;
        A1 = 11'h050; I1 = 16'h5555; CSB1 = 0; WEB1 = 0;
        tick;
        reset_N = 1;
        I1 = 16'h9999;
        tick;
        reset_N = 0; idle;
        A2 = 11'h050; CSB2 = 0; WEB2 = 1;
        tick;
        chk("write_blocked_in_reset", O2, 16'h5555);
        reset_N = 1;
        #1;
        chk("async_reset_o2", O2, 16'h0000);
        reset_N = 0; idle;
        tick;
        A1 = 11'h123; I1 = 16'hA5A5; CSB1 = 0; WEB1 = 0;
        tick;
        idle; A2 = 11'h123; CSB2 = 0;
        tick;
        chk("p1_write_p2_read", O2, 16'hA5A5);
        idle; A1 = 11'h123; CSB1 = 0;
        tick;
        chk("p1_read", O1, 16'hA5A5);
        idle; A1 = 11'h7FF; I1 = 16'h2222; CSB1 = 0; WEB1 = 0;
        tick;
        chk("no_write_through_o1", O1, 16'hA5A5);
        I1 = 16'h1111; A2 = 11'h7FF; CSB2 = 0; WEB2 = 1;
        tick;
`ifdef DPRAM_BYPASS_EN
        chk("collision_read", O2, 16'h1111);
`else
        chk("collision_read", O2, 16'h2222);
`endif
        idle; CSB2 = 0;
        tick;
        chk("collision_written", O2, 16'h1111);
        idle; A1 = 11'h000; A2 = 11'h000; I1 = 16'hBEEF; I2 = 16'hCAFE;
        CSB1 = 0; WEB1 = 0; CSB2 = 0; WEB2 = 0;
        tick;
        idle; CSB2 = 0;
        tick;
        chk("dual_write_p2", O2, 16'hBEEF);
        idle; CSB1 = 0;
        tick;
        chk("dual_write_p1", O1, 16'hBEEF);
        idle; A1 = 11'h010; I1 = 16'h0F0F; CSB1 = 0; WEB1 = 0;
        tick;
        idle; A2 = 11'h010; CSB2 = 0; OEB2 = 1;
        tick;
        chk("oeb2_hides_data", {15'b0, O2 === 16'h0F0F}, 16'h0000);
        idle; OEB2 = 0;
        #1;
        chk("oeb2_enable", O2, 16'h0F0F);
        for (int i = 0; i < 5; i++) begin
            A2 = (i % 2) ? 11'h123 : 11'h7FF;
            WEB2 = i[0];
            I2 = 16'hDEAD;
            tick;
            chk("csb2_hold", O2, 16'h0F0F);
        end
        idle; A2 = 11'h7FF; CSB2 = 0;
        tick;
        chk("deselected_no_write", O2, 16'h1111);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dpram_2048x16_cb.md
# dpram_2048x16_cb

- Synchronous true dual-port RAM, 2048 words x 16 bits, with macro-style active-low controls.
- Used as the conflict-resolve lookup table beside the conflict-resolve FSM.
- In that use, port 1 only writes and port 2 only reads; both ports are nevertheless full read/write.
- Both ports run on one clock.

## Interface
Parameters:
- DATA_WIDTH, 16, word width.
- ADDR_WIDTH, 11, address width.
- DEPTH, 2048, number of words (2**ADDR_WIDTH).

Ports:
- clk  input  1  single clock; replaces the per-port CEB1/CEB2 clock pins; all port activity on rising edge.
- reset_N  input  1  reset, asynchronous and active-high (asserted = 1) despite the suffix.
- A1  input  ADDR_WIDTH  port 1 address.
- A2  input  ADDR_WIDTH  port 2 address.
- CSB1  input  1  port 1 chip select, active low.
- CSB2  input  1  port 2 chip select, active low.
- WEB1  input  1  port 1 write enable, active low; 1 = read.
- WEB2  input  1  port 2 write enable, active low; 1 = read.
- OEB1  input  1  port 1 output enable, active low.
- OEB2  input  1  port 2 output enable, active low.
- I1  input  DATA_WIDTH  port 1 write data.
- I2  input  DATA_WIDTH  port 2 write data.
- O1  output  DATA_WIDTH  port 1 read data.
- O2  output  DATA_WIDTH  port 2 read data.

## Operation
- Port p is idle when CSBp=1: no access, output register holds its value.
- Write: CSBp=0 and WEBp=0 at a rising edge writes mem[Ap] <= Ip. The port's output register is unchanged (no same-port write-through).
- Read: CSBp=0 and WEBp=1 at a rising edge loads out_reg_p <= mem[Ap].
- Output drive: Op = out_reg_p when OEBp=0, else 'z. OEB is purely combinational and does not affect the array or registers.
- Both ports simultaneously writing the same address: port 1 data is stored; port 2's write is dropped.
- Cross-port read/write collision on the same address, same edge: the reading port returns the old contents (read-first). The DPRAM_BYPASS_EN macro changes this.
- Addresses are always in range, since DEPTH = 2**ADDR_WIDTH; there is no wrap or error logic.
- Array contents are not cleared by reset; an unwritten word reads as X in simulation.

## Timing
- Write latency: data is visible to a read issued on the next edge; same-edge collisions are handled as above.
- Read latency: 1 cycle. Op is valid after the edge that sampled the read and holds until the next read on that port or reset.
- Reset values: out_reg_1 = out_reg_2 = 0 (O1/O2 = 0 when their OEB = 0).
- Reset is asynchronous. While reset is asserted, writes are suppressed and reads do not update the registers.
- Reset asserted mid-operation aborts any access on that edge; the array keeps its prior contents.
- Normal operation resumes on the first rising edge after reset deasserts.

## Configuration
- DPRAM_BYPASS_EN defined: on a same-edge cross-port collision (one port writes address X, the other reads X), the reading port returns the newly written data (write-first bypass).
  - Under a dual-write collision it returns port 1's data.
- DPRAM_BYPASS_EN undefined: the reading port returns the old contents (read-first).

## Structure
- Shared package dpram_pkg: DPRAM_DATA_WIDTH = 16 and DPRAM_ADDR_WIDTH = 11 constants.
- Shared package dpram_pkg: typedefs dpram_addr_t and dpram_data_t.
- No sub-module is needed.
- One array declaration, one clocked write process with port-1 priority, and per-port registered read processes with async reset.
- Combinational tristate output assigns.

## Test plan
- Reset with reset_N=1 -> O1=O2=16'h0000 with OEB1=OEB2=0; a write attempted while reset_N=1 does not modify the array.
- Port 1 writes 16'hA5A5 to 11'h123 (CSB1=0, WEB1=0), then port 2 reads 11'h123 (CSB2=0, WEB2=1, OEB2=0) -> O2=16'hA5A5 one cycle after the read edge.
- Same edge: port 1 writes 16'h1111 to 11'h7FF while port 2 reads 11'h7FF, which previously held 16'h2222 -> O2=16'h2222 without DPRAM_BYPASS_EN, 16'h1111 with it.
- Both ports write 11'h000 on the same edge (I1=16'hBEEF, I2=16'hCAFE) -> a subsequent read returns 16'hBEEF.
- Read 11'h010 holding 16'h0F0F with OEB2=1 -> O2='z; then set OEB2=0 with no new read -> O2=16'h0F0F.
- Read on port 2, then hold CSB2=1 for 5 cycles while changing A2 -> O2 stays unchanged.
